// File: rtl/raiz_pkg.sv
// Shared encodings for the square-root ALU handshake: opcodes match the
// sequencer's RaizOP field; state_t is the responder FSM encoding.
package raiz_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EXEC   = 2'b01,
    ST_DIV    = 2'b10,
    ST_FINISH = 2'b11
  } state_t;

endpackage

// File: rtl/raiz_restoring_div.sv
// Restoring unsigned divider: one quotient bit per i_step, MSB first,
// WIDTH steps after i_load. o_quot is the quotient including the current step.
module raiz_restoring_div #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quot,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_shf;
  logic [WIDTH-1:0] r_dvs;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_part;
  logic [WIDTH:0]   w_diff;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_next;

  // Borrow out of the trial subtraction means the divisor did not fit.
  assign w_part     = {r_rem, r_shf[WIDTH-1]};
  assign w_diff     = w_part - {1'b0, r_dvs};
  assign w_qbit     = ~w_diff[WIDTH];
  assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_part[WIDTH-1:0];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_rem <= '0;
      r_shf <= '0;
      r_dvs <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_rem <= '0;
      r_shf <= i_dividend;
      r_dvs <= i_divisor;
      r_cnt <= CNT_W'(WIDTH);
    end else if (i_step && (r_cnt != '0)) begin
      r_rem <= w_rem_next;
      r_shf <= {r_shf[WIDTH-2:0], w_qbit};
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_quot = {r_shf[WIDTH-2:0], w_qbit};
  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/raiz_seq_alu.sv
// Multi-cycle ALU responder for the square-root sequencer: ADD/SUB/SHR in one
// execute cycle, DIV through the restoring divider, one-cycle DONE afterwards.
module raiz_seq_alu
  import raiz_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ALURST,
  input  logic             START,
  input  logic [1:0]       OPCODE,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] RESULT,
  output logic             DONE,
  output logic             BUSY,
  output logic             CARRY,
  output logic             NEG,
  output logic             DIVZ
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;

  logic             w_clr;
  logic             w_accept;
  logic             w_div_load;
  logic [WIDTH-1:0] w_div_quot;
  logic [CNT_W-1:0] w_div_cnt;
  logic             w_div_last;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic             w_neg;
  logic             w_divz;

  assign w_clr      = RST | ALURST;
  assign w_accept   = (r_state == ST_IDLE) && START;
  assign w_div_load = w_accept && (OPCODE == OP_DIV) && (B != '0);

  raiz_restoring_div #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .i_clk      (CLK),
    .i_clr      (w_clr),
    .i_load     (w_div_load),
    .i_step     (r_state == ST_DIV),
    .i_dividend (A),
    .i_divisor  (B),
    .o_quot     (w_div_quot),
    .o_cnt      (w_div_cnt),
    .o_last     (w_div_last)
  );

  always_ff @(posedge CLK) begin
    if (w_clr) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (START) w_next = ((OPCODE == OP_DIV) && (B != '0)) ? ST_DIV : ST_EXEC;
      ST_EXEC:   w_next = ST_FINISH;
      // Empty counter exit keeps the FSM from parking in DIV if ever unloaded.
      ST_DIV:    if (w_div_last || (w_div_cnt == '0)) w_next = ST_FINISH;
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    DONE = (r_state == ST_FINISH);
    BUSY = (r_state != ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (w_clr) begin
      r_op <= OP_ADD;
      r_a  <= '0;
      r_b  <= '0;
    end else if (w_accept) begin
      r_op <= OPCODE;
      r_a  <= A;
      r_b  <= B;
    end
  end

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    w_neg   = 1'b0;
    w_divz  = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_res   = w_sum[WIDTH-1:0];
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res = w_diff[WIDTH-1:0];
        w_neg = w_diff[WIDTH];
      end
      OP_SHR: w_res = {1'b0, r_a[WIDTH-1:1]};
      default: begin
        w_res  = '1;
        w_divz = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_clr) begin
      RESULT <= '0;
      CARRY  <= 1'b0;
      NEG    <= 1'b0;
      DIVZ   <= 1'b0;
    end else if (r_state == ST_EXEC) begin
      RESULT <= w_res;
      CARRY  <= w_carry;
      NEG    <= w_neg;
      DIVZ   <= w_divz;
    end else if ((r_state == ST_DIV) && w_div_last) begin
      RESULT <= w_div_quot;
      CARRY  <= 1'b0;
      NEG    <= 1'b0;
      DIVZ   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_raiz_seq_alu.sv
// Self-checking bench for raiz_seq_alu against an arithmetic reference model.
module tb_raiz_seq_alu;

  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         ALURST = 1'b0;
  logic         START = 1'b0;
  logic [1:0]   OPCODE = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] RESULT;
  logic         DONE, BUSY, CARRY, NEG, DIVZ;

  int n_checks = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] res;
    logic        carry;
    logic        neg;
    logic        divz;
    logic [7:0]  lat;
  } exp_t;

  raiz_seq_alu #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .ALURST(ALURST), .START(START), .OPCODE(OPCODE),
    .A(A), .B(B), .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY),
    .CARRY(CARRY), .NEG(NEG), .DIVZ(DIVZ)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic exp_t ref_op(input logic [1:0] op, input logic [15:0] a_in, input logic [15:0] b_in);
    exp_t e;
    int a, b, s;
    a = int'(a_in);
    b = int'(b_in);
    e = '0;
    e.lat = 8'd2;
    case (op)
      2'd0: begin s = a + b; e.res = 16'(s % 65536); e.carry = (s > 65535); end
      2'd1: begin e.res = 16'((a - b + 65536) % 65536); e.neg = (a < b); end
      2'd2: e.res = 16'(a / 2);
      default: begin
        if (b == 0) begin e.res = 16'hFFFF; e.divz = 1'b1; end
        else begin e.res = 16'(a / b); e.lat = 8'(W + 1); end
      end
    endcase
    return e;
  endfunction

  // Drives one request, scrambles the operand inputs afterwards, waits for DONE.
  task automatic do_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                       output exp_t obs, output int busy_gaps, output logic done_after);
    OPCODE = op; A = a; B = b; START = 1'b1;
    tick();
    START = 1'b0; A = 16'($urandom); B = 16'($urandom); OPCODE = 2'($urandom);
    obs = '0;
    busy_gaps = 0;
    for (int k = 1; k <= 40; k++) begin
      if (BUSY !== 1'b1) busy_gaps++;
      if (DONE === 1'b1) begin obs.lat = 8'(k); break; end
      tick();
    end
    obs.res = RESULT; obs.carry = CARRY; obs.neg = NEG; obs.divz = DIVZ;
    tick();
    done_after = DONE;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b1; OPCODE = 2'b00; A = 16'h1234; B = 16'h1111;
    tick(); tick();
    n_checks++;
    if ({RESULT, DONE, BUSY, CARRY, NEG, DIVZ} !== 21'd0) begin
      n_bad++; $display("FAIL reset_outputs got=%h want=0", {RESULT, DONE, BUSY, CARRY, NEG, DIVZ});
    end
    RST = 1'b0; START = 1'b0;
    tick();
  endtask

  task automatic test_add();
    exp_t obs, e; int gaps; logic da;
    n_checks++;
    if (BUSY !== 1'b0) begin n_bad++; $display("FAIL add_idle_busy got=%b want=0", BUSY); end
    e = ref_op(2'b00, 16'hFFFF, 16'h0002);
    do_op(2'b00, 16'hFFFF, 16'h0002, obs, gaps, da);
    n_checks++;
    if (obs !== e || e.res !== 16'h0001 || e.carry !== 1'b1) begin
      n_bad++; $display("FAIL add_wrap got=%h want=%h", obs, e);
    end
    n_checks++;
    if (gaps != 0 || da !== 1'b0) begin
      n_bad++; $display("FAIL add_busy_done got gaps=%0d done_after=%b want gaps=0 done_after=0", gaps, da);
    end
  endtask

  task automatic test_sub();
    exp_t obs, e; int gaps; logic da;
    e = ref_op(2'b01, 16'd5, 16'd7);
    do_op(2'b01, 16'd5, 16'd7, obs, gaps, da);
    n_checks++;
    if (obs !== e || e.res !== 16'hFFFE) begin n_bad++; $display("FAIL sub_borrow got=%h want=%h", obs, e); end
    e = ref_op(2'b01, 16'd7, 16'd5);
    do_op(2'b01, 16'd7, 16'd5, obs, gaps, da);
    n_checks++;
    if (obs !== e || e.res !== 16'h0002) begin n_bad++; $display("FAIL sub_plain got=%h want=%h", obs, e); end
  endtask

  task automatic test_shr();
    exp_t obs, e; int gaps; logic da;
    e = ref_op(2'b10, 16'h0031, 16'hAAAA);
    do_op(2'b10, 16'h0031, 16'hAAAA, obs, gaps, da);
    n_checks++;
    if (obs !== e || e.res !== 16'h0018) begin n_bad++; $display("FAIL shr got=%h want=%h", obs, e); end
  endtask

  task automatic test_div();
    exp_t obs, e; int gaps; logic da;
    e = ref_op(2'b11, 16'd1000, 16'd7);
    do_op(2'b11, 16'd1000, 16'd7, obs, gaps, da);
    n_checks++;
    if (obs !== e || e.res !== 16'd142 || e.lat !== 8'd17) begin n_bad++; $display("FAIL div got=%h want=%h", obs, e); end
    n_checks++;
    if (gaps != 0 || da !== 1'b0) begin n_bad++; $display("FAIL div_busy_done got gaps=%0d done_after=%b want 0/0", gaps, da); end
    e = ref_op(2'b11, 16'd5, 16'd0);
    do_op(2'b11, 16'd5, 16'd0, obs, gaps, da);
    n_checks++;
    if (obs !== e || e.divz !== 1'b1) begin n_bad++; $display("FAIL div_zero got=%h want=%h", obs, e); end
  endtask

  task automatic test_held_start();
    exp_t e1, e2, obs; int dones, done_k; logic [15:0] res1; logic [1:0] op2; logic [15:0] a2, b2;
    e1 = ref_op(2'b11, 16'd1000, 16'd7);
    OPCODE = 2'b11; A = 16'd1000; B = 16'd7; START = 1'b1;
    dones = 0; done_k = 0; res1 = '0;
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (DONE === 1'b1) begin dones++; if (done_k == 0) done_k = k; end
      if (k == 17) res1 = RESULT;
      OPCODE = 2'($urandom); A = 16'($urandom); B = 16'($urandom);
    end
    n_checks++;
    if (done_k != 17 || dones != 1 || res1 !== e1.res) begin
      n_bad++; $display("FAIL held_first got k=%0d dones=%0d res=%h want k=17 dones=1 res=%h", done_k, dones, res1, e1.res);
    end
    tick();
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_bad++; $display("FAIL held_idle got busy=%b done=%b want 0/0", BUSY, DONE); end
    op2 = 2'($urandom); a2 = 16'($urandom); b2 = 16'($urandom_range(0, 300));
    OPCODE = op2; A = a2; B = b2;
    e2 = ref_op(op2, a2, b2);
    tick();
    START = 1'b0; A = 16'($urandom); B = 16'($urandom);
    obs = '0;
    for (int k = 1; k <= 40; k++) begin
      if (DONE === 1'b1) begin obs.lat = 8'(k); break; end
      tick();
    end
    obs.res = RESULT; obs.carry = CARRY; obs.neg = NEG; obs.divz = DIVZ;
    n_checks++;
    if (obs !== e2) begin n_bad++; $display("FAIL held_retrigger op=%0d got=%h want=%h", op2, obs, e2); end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [15:0] a, b;
    a = 16'($urandom); b = 16'($urandom);
    e = ref_op(2'b00, a, b);
    OPCODE = 2'b00; A = a; B = b; START = 1'b1;
    tick();
    OPCODE = 2'b01; A = 16'($urandom); B = 16'($urandom);
    tick();
    START = 1'b0;
    n_checks++;
    if (DONE !== 1'b1 || RESULT !== e.res || CARRY !== e.carry) begin
      n_bad++; $display("FAIL b2b_first got done=%b res=%h c=%b want 1 %h %b", DONE, RESULT, CARRY, e.res, e.carry);
    end
    tick();
    n_checks++;
    if (BUSY !== 1'b0 || DONE !== 1'b0) begin n_bad++; $display("FAIL b2b_no_queue got busy=%b done=%b want 0/0", BUSY, DONE); end
  endtask

  task automatic test_alurst();
    exp_t obs; int gaps, dones; logic da; logic busy5;
    do_op(2'b00, 16'd3, 16'd4, obs, gaps, da);
    OPCODE = 2'b11; A = 16'd1000; B = 16'd7; START = 1'b1;
    tick();
    START = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    busy5 = BUSY;
    ALURST = 1'b1;
    tick();
    ALURST = 1'b0;
    n_checks++;
    if (busy5 !== 1'b1 || {RESULT, DONE, BUSY, CARRY, NEG, DIVZ} !== 21'd0) begin
      n_bad++; $display("FAIL alurst_abort got busy5=%b out=%h want busy5=1 out=0", busy5, {RESULT, DONE, BUSY, CARRY, NEG, DIVZ});
    end
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (DONE !== 1'b0 || BUSY !== 1'b0) dones++;
      tick();
    end
    n_checks++;
    if (dones != 0) begin n_bad++; $display("FAIL alurst_quiet got activity=%0d want 0", dones); end
  endtask

  task automatic test_reset_vs_start();
    exp_t obs; int gaps; logic da;
    do_op(2'b00, 16'd9, 16'd9, obs, gaps, da);
    RST = 1'b1; START = 1'b1; OPCODE = 2'b00; A = 16'd1; B = 16'd1;
    tick();
    RST = 1'b0; START = 1'b0;
    tick();
    n_checks++;
    if ({RESULT, DONE, BUSY, CARRY, NEG, DIVZ} !== 21'd0) begin
      n_bad++; $display("FAIL rst_start got=%h want=0", {RESULT, DONE, BUSY, CARRY, NEG, DIVZ});
    end
    do_op(2'b00, 16'd9, 16'd9, obs, gaps, da);
    ALURST = 1'b1; START = 1'b1; OPCODE = 2'b11; A = 16'd100; B = 16'd3;
    tick();
    ALURST = 1'b0; START = 1'b0;
    tick();
    n_checks++;
    if ({RESULT, DONE, BUSY, CARRY, NEG, DIVZ} !== 21'd0) begin
      n_bad++; $display("FAIL alurst_start got=%h want=0", {RESULT, DONE, BUSY, CARRY, NEG, DIVZ});
    end
  endtask

  task automatic test_random();
    exp_t obs, e; int gaps; logic da; logic [1:0] op; logic [15:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = 16'd0;
        1:       b = 16'($urandom_range(1, 20));
        default: b = 16'($urandom);
      endcase
      e = ref_op(op, a, b);
      do_op(op, a, b, obs, gaps, da);
      n_checks++;
      if (obs !== e || gaps != 0 || da !== 1'b0) begin
        n_bad++; $display("FAIL random_%0d op=%0d a=%h b=%h got=%h gaps=%0d da=%b want=%h", i, op, a, b, obs, gaps, da, e);
      end
      for (int j = $urandom_range(0, 2); j > 0; j--) tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shr();
    test_div();
    test_held_start();
    test_back_to_back();
    test_alurst();
    test_reset_vs_start();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/raiz_seq_alu.md
Name: raiz_seq_alu

Overview:
- Multi-cycle unsigned arithmetic responder on the far side of the square-root sequencer's ALU handshake.
- Accepts a one-cycle-or-longer START with opcode and two operands, computes, then returns a one-cycle DONE with a held RESULT.
- Provides the four Newton-iteration operations: add, subtract/compare, halve, and iterative divide.
- Sits between the operand muxes (A/B) and the C/Z/D/Y register file of the root datapath.

Parameters:
WIDTH, 16, operand/result width in bits (unsigned)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous, active-high reset
ALURST  input  1  synchronous soft clear from sequencer; same effect as RST
START  input  1  request; sampled only in IDLE
OPCODE  input  2  00 ADD, 01 SUB, 10 SHR, 11 DIV; latched with START
A  input  WIDTH  operand A, latched with START
B  input  WIDTH  operand B, latched with START
RESULT  output  WIDTH  result of last completed op, held until next completion
DONE  output  1  one-cycle completion pulse
BUSY  output  1  high in every state except IDLE
CARRY  output  1  ADD carry-out; 0 for other ops
NEG  output  1  SUB borrow (A<B); 0 for other ops
DIVZ  output  1  DIV with B==0; 0 for other ops

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports CLK, RST).
- Reset (RST or ALURST): state IDLE; RESULT=0, DONE=0, BUSY=0, CARRY=0, NEG=0, DIVZ=0; divider counter/remainder cleared.
- Priority: RST > ALURST > START. ALURST and START high in the same cycle: START is discarded.
- States: IDLE, EXEC, DIV, FINISH.
  - IDLE: START=1 latches OPCODE/A/B. Next state is DIV if OPCODE=11 and B!=0, otherwise EXEC.
  - EXEC: compute once; load RESULT and flags; next state FINISH.
  - DIV: restoring division, one quotient bit per cycle, MSB first, over exactly WIDTH cycles. After the last bit, load RESULT and flags; next state FINISH.
  - FINISH: DONE=1 for this cycle only; next state IDLE.
- Latency, with START sampled high in cycle c:
  - DONE is high in cycle c+2 for ADD, SUB, SHR and DIV-by-zero.
  - DONE is high in cycle c+WIDTH+1 for DIV.
- START is ignored in EXEC, DIV and FINISH; nothing is queued. Minimum START-to-START spacing is 3 cycles.
- A level-held START re-triggers on the first IDLE cycle.
- Arithmetic (unsigned, width WIDTH):
  - ADD: RESULT=(A+B) mod 2^WIDTH; CARRY=bit WIDTH of the sum.
  - SUB: RESULT=(A-B) mod 2^WIDTH; NEG=(A<B).
  - SHR: RESULT=A>>1 with zero fill; B ignored.
  - DIV: RESULT=floor(A/B); remainder discarded.
  - DIV with B=0: RESULT=all ones, DIVZ=1.
- RESULT and flags change only on the transition into FINISH, or on reset. Operands may change freely after the latching cycle.
- Reset mid-operation: takes effect at the next edge. No DONE is issued for the aborted op, and RESULT goes to 0.

Decomposition:
- Shared package raiz_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_SHR=2'b10, OP_DIV=2'b11, shared with the sequencer's RaizOP encoding;
  - state encoding for IDLE/EXEC/DIV/FINISH.
- One sub-module, raiz_restoring_div:
  - WIDTH-cycle restoring divider with load/step inputs;
  - outputs: quotient, bit counter, last-step flag.
- The top level keeps the FSM, ADD/SUB/SHR and the output registers.

Test Plan:
- WIDTH=16, ADD A=0xFFFF B=0x0002 -> RESULT=0x0001, CARRY=1, NEG=0, DONE single pulse in cycle c+2, BUSY high c+1..c+2.
- SUB A=5 B=7 -> RESULT=0xFFFE, NEG=1. Then SUB A=7 B=5 -> RESULT=0x0002, NEG=0.
- SHR A=0x0031 B=0xAAAA -> RESULT=0x0018, all flags 0.
- DIV A=1000 B=7 -> RESULT=142 with DONE in cycle c+17. Then DIV A=5 B=0 -> RESULT=0xFFFF, DIVZ=1, DONE in c+2.
- START held high and OPCODE/A/B toggled during a DIV -> operands latched at c are used, no second DONE before FINISH, new op begins on the following IDLE cycle.
- ALURST pulsed at c+5 of a DIV -> IDLE next cycle, DONE never asserted, RESULT=0, BUSY=0. RST and START together -> START discarded, outputs stay at reset values.
